// File: rtl/barcode_2of5_bar_reader.sv
// barcode_2of5_bar_reader
// Samples the optical bar sensor, measures bar widths, classifies bars as
// narrow/wide, tracks start / data / stop patterns and hands each completed
// 5-bar symbol (E4..E0, first bar in code[4]) downstream via valid/ready.
// Optional feature macro: BARCODE_WEIGHT_CHECK_EN (reject symbols whose
// popcount is not 2 instead of emitting them).
module barcode_2of5_bar_reader #(
  parameter int CNT_W        = 16,
  parameter int MIN_BAR      = 2,
  parameter int WIDE_MIN     = 8,
  parameter int MAX_BAR      = 32,
  parameter int QUIET_CYCLES = 40,
  parameter int MAX_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bar_in,
  output logic [4:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [2:0] digit_count,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_BAR);
  localparam logic [CNT_W-1:0] WIDE_W  = CNT_W'(WIDE_MIN);
  localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_BAR);
  localparam logic [CNT_W-1:0] QUIET_W = CNT_W'(QUIET_CYCLES);
  localparam logic [2:0]       MAX_D   = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

`ifdef BARCODE_WEIGHT_CHECK_EN
  // Number of set bits in a 5-bit symbol; a legal 2-of-5 symbol has two.
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction
`endif

  // Input path state
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_s, bar_end_s, quiet_s;
  // Event pipeline: stage 1 captures raw events, stage 2 the classification
  logic             ev1_bar_q, ev1_bar_d, ev1_quiet_q, ev1_quiet_d;
  logic [CNT_W-1:0] ev1_w_q, ev1_w_d;
  logic             ev2_bar_q, ev2_bar_d, ev2_quiet_q, ev2_quiet_d;
  logic             ev2_err_q, ev2_err_d, ev2_bit_q, ev2_bit_d;
  // Frame tracking and output state
  state_t           state_q, state_d;
  logic [2:0]       nbits_q, nbits_d;
  logic [4:0]       shreg_q, shreg_d;
  logic [2:0]       digit_count_q, digit_count_d;
  logic [4:0]       code_q, code_d;
  logic             code_valid_q, code_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [4:0]       shift_s;
  logic [2:0]       nbits_inc_s;
  logic             weight_ok_s;

  // Synchronizer, width counter, event detection and bar classification
  always_comb begin
    s1_d      = bar_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    edge_s    = s2_q ^ s3_q;
    if (edge_s) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // A falling edge of the synchronized line ends a bar whose width is cnt_q
    bar_end_s = s3_q & ~s2_q;
    // The edge guard keeps a bar that ends at exactly QUIET_W from firing
    quiet_s   = ~s2_q & ~edge_s & (cnt_q == QUIET_W);
    ev1_bar_d   = bar_end_s;
    ev1_quiet_d = quiet_s;
    ev1_w_d     = cnt_q;
    ev2_bar_d   = ev1_bar_q;
    ev2_quiet_d = ev1_quiet_q;
    if ((ev1_w_q < MIN_W) || (ev1_w_q > MAX_W)) begin
      ev2_err_d = 1'b1;
    end else begin
      ev2_err_d = 1'b0;
    end
    ev2_bit_d = (ev1_w_q >= WIDE_W);
  end

  // Frame FSM: start/data/stop tracking, symbol emit and handshake
  always_comb begin
    state_d       = state_q;
    nbits_d       = nbits_q;
    shreg_d       = shreg_q;
    digit_count_d = digit_count_q;
    code_d        = code_q;
    overrun_d     = overrun_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    shift_s       = {shreg_q[3:0], ev2_bit_q};
    nbits_inc_s   = nbits_q + 3'd1;
`ifdef BARCODE_WEIGHT_CHECK_EN
    weight_ok_s   = (popcount5(shift_s) == 3'd2);
`else
    weight_ok_s   = 1'b1;
`endif
    // An accepted symbol retires unless a new one is loaded below
    if (code_valid_q && code_ready) begin
      code_valid_d = 1'b0;
    end else begin
      code_valid_d = code_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Bars are ignored until a full quiet zone establishes framing
        if (ev2_quiet_q) begin
          state_d       = ST_ARMED;
          nbits_d       = 3'd0;
          digit_count_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (ev2_bar_q && ev2_err_q) begin
          frame_err_d   = 1'b1;
          nbits_d       = 3'd0;
          digit_count_d = 3'd0;
        end else if (ev2_bar_q) begin
          shreg_d = shift_s;
          if (nbits_inc_s == 3'd3) begin
            nbits_d = 3'd0;
            if (shift_s[2:0] == 3'b110) begin
              state_d = ST_DATA;
            end else begin
              frame_err_d   = 1'b1;
              digit_count_d = 3'd0;
            end
          end else begin
            nbits_d = nbits_inc_s;
          end
        end else if (ev2_quiet_q) begin
          // A quiet zone after a partial start pattern is a framing error
          if (nbits_q != 3'd0) begin
            frame_err_d   = 1'b1;
            nbits_d       = 3'd0;
            digit_count_d = 3'd0;
          end else begin
            nbits_d = 3'd0;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_DATA: begin
        if (ev2_bar_q && ev2_err_q) begin
          frame_err_d   = 1'b1;
          state_d       = ST_ARMED;
          nbits_d       = 3'd0;
          digit_count_d = 3'd0;
        end else if (ev2_bar_q) begin
          shreg_d = shift_s;
          if (nbits_inc_s == 3'd5) begin
            nbits_d = 3'd0;
            if ((digit_count_q >= MAX_D) || !weight_ok_s) begin
              frame_err_d   = 1'b1;
              state_d       = ST_ARMED;
              digit_count_d = 3'd0;
            end else if (!code_valid_q || code_ready) begin
              code_d        = shift_s;
              code_valid_d  = 1'b1;
              digit_count_d = digit_count_q + 3'd1;
            end else begin
              // Downstream still holds the previous symbol: drop this one
              overrun_d = 1'b1;
            end
          end else begin
            nbits_d = nbits_inc_s;
          end
        end else if (ev2_quiet_q) begin
          // Only a complete stop pattern after at least one digit closes a frame
          if ((nbits_q == 3'd3) && (shreg_q[2:0] == 3'b101) &&
              (digit_count_q != 3'd0)) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d       = ST_ARMED;
          nbits_d       = 3'd0;
          digit_count_d = 3'd0;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        nbits_d       = 3'd0;
        digit_count_d = 3'd0;
      end
    endcase
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      ev1_bar_q     <= 1'b0;
      ev1_quiet_q   <= 1'b0;
      ev1_w_q       <= '0;
      ev2_bar_q     <= 1'b0;
      ev2_quiet_q   <= 1'b0;
      ev2_err_q     <= 1'b0;
      ev2_bit_q     <= 1'b0;
      state_q       <= ST_IDLE;
      nbits_q       <= 3'd0;
      shreg_q       <= 5'd0;
      digit_count_q <= 3'd0;
      code_q        <= 5'd0;
      code_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      cnt_q         <= cnt_d;
      ev1_bar_q     <= ev1_bar_d;
      ev1_quiet_q   <= ev1_quiet_d;
      ev1_w_q       <= ev1_w_d;
      ev2_bar_q     <= ev2_bar_d;
      ev2_quiet_q   <= ev2_quiet_d;
      ev2_err_q     <= ev2_err_d;
      ev2_bit_q     <= ev2_bit_d;
      state_q       <= state_d;
      nbits_q       <= nbits_d;
      shreg_q       <= shreg_d;
      digit_count_q <= digit_count_d;
      code_q        <= code_d;
      code_valid_q  <= code_valid_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign digit_count = digit_count_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
